// File: rtl/striping.sv
// striping: transmit-side two-lane word striper.
// Valid input words are routed alternately to lane_0 and lane_1, one clk_2f
// cycle of latency, each lane with a one-cycle valid pulse per word.
// Optional feature macro: STRIPING_ALIGN_EN -- when defined, every idle
// cycle (valid_in=0) re-aligns the selector so the next burst starts on lane_0.
module striping #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_2f,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] lane_0,
  output logic [DATA_WIDTH-1:0] lane_1,
  output logic                  valid_0,
  output logic                  valid_1
);

  // Selector states: which lane receives the next valid word.
  localparam logic SEL0 = 1'b0;
  localparam logic SEL1 = 1'b1;

  logic                  sel_q, sel_d;
  logic [DATA_WIDTH-1:0] lane_0_q, lane_0_d;
  logic [DATA_WIDTH-1:0] lane_1_q, lane_1_d;
  logic                  valid_0_q, valid_0_d;
  logic                  valid_1_q, valid_1_d;

  // Next-state: route a valid word to the selected lane; idle cycles only drop the valids.
  always_comb begin
    sel_d     = sel_q;
    lane_0_d  = lane_0_q;
    lane_1_d  = lane_1_q;
    valid_0_d = 1'b0;
    valid_1_d = 1'b0;
    if (valid_in) begin
      case (sel_q)
        SEL0: begin
          lane_0_d  = data_in;
          valid_0_d = 1'b1;
          sel_d     = SEL1;
        end
        default: begin
          lane_1_d  = data_in;
          valid_1_d = 1'b1;
          sel_d     = SEL0;
        end
      endcase
    end else begin
`ifdef STRIPING_ALIGN_EN
      // Idle cycle marks a burst boundary: the next burst starts on lane_0.
      sel_d = SEL0;
`else
      // Alternation carries across idle gaps.
      sel_d = sel_q;
`endif
    end
  end

  // State registers with immediate clear on reset.
  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      sel_q     <= SEL0;
      lane_0_q  <= '0;
      lane_1_q  <= '0;
      valid_0_q <= 1'b0;
      valid_1_q <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      lane_0_q  <= lane_0_d;
      lane_1_q  <= lane_1_d;
      valid_0_q <= valid_0_d;
      valid_1_q <= valid_1_d;
    end
  end

  assign lane_0  = lane_0_q;
  assign lane_1  = lane_1_q;
  assign valid_0 = valid_0_q;
  assign valid_1 = valid_1_q;

endmodule
